// File: rtl/motor_pkg.sv
// Shared types for the motor ramp channel: the sequencer state encoding
// and the H-bridge direction encoding.
package motor_pkg;

    // Sequencer states. IDLE means the output has settled on the target.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        DEAD  = 2'd2,
        BRAKE = 2'd3
    } motor_state_e;

    // Direction encoding as seen by the H-bridge.
    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;

endpackage

// File: rtl/motor_ramp_divider.sv
// Free-running tick generator: one-cycle pulse every DIV clock cycles.
// The counter restarts from zero on reset so the tick phase is known.
module Divider #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Wrap-around counter; the tick is the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/motor_ramp.sv
// Slew-rate limiter and direction sequencer in front of the PWM generator.
// Signed speed commands arrive on a valid/ready handshake; the duty output
// moves toward the commanded magnitude by STEP once per ramp tick, and a
// reversal is sequenced as ramp-down, dead time, direction flip, ramp-up.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on the state register
// (low during dead time), never on cmd_valid. A transferred command
// replaces the target at once; nothing is queued.
import motor_pkg::*;

module motor_ramp #(
    parameter int DUTY_W      = 10,
    parameter int STEP_DIV    = 1000,
    parameter int STEP        = 8,
    parameter int DEAD_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W:0]   cmd_speed,
    input  logic              cmd_brake,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic              brake,
    output logic              at_target,
    output motor_state_e      fsm_state
);

    // Ramp arithmetic is one bit wider than duty so sums never wrap.
    localparam int W1   = DUTY_W + 1;
    localparam int DC_W = $clog2(DEAD_CYCLES + 1);

    localparam logic [W1-1:0]     STEP_X    = W1'(STEP);
    localparam logic [DC_W-1:0]   DEAD_LAST = DC_W'(DEAD_CYCLES - 1);
    localparam logic [DUTY_W-1:0] MAG_MAX   = {DUTY_W{1'b1}};

    motor_state_e state;
    motor_state_e state_next;

    // Target held between commands.
    logic [DUTY_W-1:0] tgt_mag;
    logic              tgt_dir;

    // Dead-time cycle counter.
    logic [DC_W-1:0] dead_cnt;

    // Next values of the registered datapath.
    logic [DUTY_W-1:0] duty_next;
    logic              dir_next;
    logic              brake_next;
    logic [DUTY_W-1:0] tgt_mag_next;
    logic              tgt_dir_next;
    logic [DC_W-1:0]   dead_cnt_next;

    // Command decode.
    logic              fire;
    logic              cmd_neg;
    logic [W1-1:0]     cmd_abs;
    logic [DUTY_W-1:0] cmd_mag;
    logic              cmd_dir;
    logic              cmd_same;

    // Ramp step results for the current duty and the held target.
    logic          tick;
    logic          ramp_tick;
    logic [W1-1:0] duty_x;
    logic [W1-1:0] tgt_x;
    logic [W1-1:0] step_duty;
    logic          step_settled;
    logic          step_zero_rev;
    logic          dead_done;

    Divider #(STEP_DIV) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign fire      = cmd_valid && cmd_ready;
    assign ramp_tick = (state == RAMP) && tick;
    assign dead_done = (state == DEAD) && (dead_cnt == DEAD_LAST);
    assign fsm_state = state;

    // Decode the incoming command into magnitude and direction; the most
    // negative speed has no positive twin and saturates to full scale.
    always_comb begin
        cmd_neg  = cmd_speed[DUTY_W];
        cmd_abs  = cmd_neg ? (W1'(0) - cmd_speed) : cmd_speed;
        cmd_mag  = cmd_abs[DUTY_W] ? MAG_MAX : cmd_abs[DUTY_W-1:0];
        cmd_dir  = (cmd_speed == '0) ? dir : (cmd_neg ? REV : FWD);
        cmd_same = (cmd_mag == duty) && (cmd_dir == dir);
    end

    // One ramp step toward the held target; a pending reversal first
    // drives duty to zero, otherwise the step is clamped at the target.
    always_comb begin
        duty_x        = {1'b0, duty};
        tgt_x         = {1'b0, tgt_mag};
        step_duty     = duty_x;
        step_settled  = 1'b0;
        step_zero_rev = 1'b0;
        if (dir != tgt_dir) begin
            step_duty     = (duty_x > STEP_X) ? (duty_x - STEP_X) : '0;
            step_zero_rev = (step_duty == '0);
        end else if (duty_x < tgt_x) begin
            if ((tgt_x - duty_x) <= STEP_X) begin
                step_duty    = tgt_x;
                step_settled = 1'b1;
            end else begin
                step_duty = duty_x + STEP_X;
            end
        end else if (duty_x > tgt_x) begin
            if ((duty_x - tgt_x) <= STEP_X) begin
                step_duty    = tgt_x;
                step_settled = 1'b1;
            end else begin
                step_duty = duty_x - STEP_X;
            end
        end else begin
            step_settled = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: ramp/dead progress first, then an accepted
    // command overrides. A command landing on a ramp tick keeps RAMP so
    // the new target is evaluated on the following tick.
    always_comb begin
        state_next = state;
        case (state)
            RAMP: begin
                if (ramp_tick) begin
                    if (step_zero_rev) begin
                        state_next = DEAD;
                    end else if (step_settled) begin
                        state_next = IDLE;
                    end
                end
            end
            DEAD: begin
                if (dead_done) begin
                    state_next = (tgt_mag == '0) ? IDLE : RAMP;
                end
            end
            default: begin
            end
        endcase
        if (fire) begin
            if (cmd_brake) begin
                state_next = BRAKE;
            end else if (state == BRAKE) begin
                // Braked counts as stopped, but the bridge still needs dead time.
                state_next = (cmd_dir != dir) ? DEAD : RAMP;
            end else if (ramp_tick) begin
                state_next = RAMP;
            end else if (cmd_same) begin
                state_next = IDLE;
            end else begin
                state_next = RAMP;
            end
        end
    end

    // Handshake and status outputs, decoded from the state register only.
    always_comb begin
        cmd_ready = (state != DEAD);
        at_target = (state == IDLE);
    end

    // Datapath next values: step on ticks, count dead time, flip the
    // bridge at the end of dead time, and load targets from commands.
    always_comb begin
        duty_next     = duty;
        dir_next      = dir;
        brake_next    = brake;
        tgt_mag_next  = tgt_mag;
        tgt_dir_next  = tgt_dir;
        dead_cnt_next = dead_cnt;
        if (state == DEAD) begin
            if (dead_done) begin
                dir_next      = ~dir;
                dead_cnt_next = '0;
            end else begin
                dead_cnt_next = dead_cnt + DC_W'(1);
            end
        end
        if (ramp_tick) begin
            duty_next = step_duty[DUTY_W-1:0];
        end
        if (fire) begin
            if (cmd_brake) begin
                tgt_mag_next = '0;
                tgt_dir_next = dir;
                duty_next    = '0;
                brake_next   = 1'b1;
            end else begin
                tgt_mag_next  = cmd_mag;
                tgt_dir_next  = cmd_dir;
                brake_next    = 1'b0;
                dead_cnt_next = '0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty     <= '0;
            dir      <= FWD;
            brake    <= 1'b0;
            tgt_mag  <= '0;
            tgt_dir  <= FWD;
            dead_cnt <= '0;
        end else begin
            duty     <= duty_next;
            dir      <= dir_next;
            brake    <= brake_next;
            tgt_mag  <= tgt_mag_next;
            tgt_dir  <= tgt_dir_next;
            dead_cnt <= dead_cnt_next;
        end
    end

endmodule

// File: tb/tb_motor_ramp.sv
// Bench for motor_ramp: directed scenarios with expected duty sequences,
// then randomized commands compared cycle by cycle against a behavioural
// model of the ramp/dead-time/brake rules.
module tb_motor_ramp;
    import motor_pkg::*;

    localparam int DUTY_W      = 10;
    localparam int STEP_DIV    = 4;
    localparam int STEP        = 16;
    localparam int DEAD_CYCLES = 8;
    localparam int W1          = DUTY_W + 1;
    localparam int MAX_MAG     = (1 << DUTY_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_RAMP  = 1;
    localparam int M_DEAD  = 2;
    localparam int M_BRAKE = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W:0]   cmd_speed;
    logic              cmd_brake;
    logic [DUTY_W-1:0] duty;
    logic              dir;
    logic              brake;
    logic              at_target;
    motor_state_e      fsm_state;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    motor_ramp #(
        .DUTY_W      (DUTY_W),
        .STEP_DIV    (STEP_DIV),
        .STEP        (STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_speed (cmd_speed),
        .cmd_brake (cmd_brake),
        .duty      (duty),
        .dir       (dir),
        .brake     (brake),
        .at_target (at_target),
        .fsm_state (fsm_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    int m_duty, m_dir, m_brake, m_tgt, m_tdir, m_mode, m_dead_left, m_div;

    always @(posedge clk) begin : ref_model
        int tick_now, acc, s, mag, d, old_mode;
        if (reset) begin
            m_duty = 0; m_dir = 0; m_brake = 0; m_tgt = 0; m_tdir = 0;
            m_mode = M_IDLE; m_dead_left = 0; m_div = 0;
        end else begin
            tick_now = (m_div == STEP_DIV - 1);
            m_div    = (m_div + 1) % STEP_DIV;
            old_mode = m_mode;
            acc      = cmd_valid && (old_mode != M_DEAD);
            if (old_mode == M_RAMP && tick_now) begin
                if (m_dir != m_tdir) begin
                    m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
                    if (m_duty == 0) begin
                        m_mode = M_DEAD;
                        m_dead_left = DEAD_CYCLES;
                    end
                end else begin
                    if (m_duty < m_tgt) m_duty = (m_duty + STEP < m_tgt) ? m_duty + STEP : m_tgt;
                    else m_duty = (m_duty - STEP > m_tgt) ? m_duty - STEP : m_tgt;
                    if (m_duty == m_tgt) m_mode = M_IDLE;
                end
            end else if (old_mode == M_DEAD) begin
                m_dead_left = m_dead_left - 1;
                if (m_dead_left == 0) begin
                    m_dir  = 1 - m_dir;
                    m_mode = (m_tgt == 0) ? M_IDLE : M_RAMP;
                end
            end
            if (acc) begin
                s   = $signed(cmd_speed);
                mag = (s < 0) ? -s : s;
                if (mag > MAX_MAG) mag = MAX_MAG;
                d   = (s == 0) ? m_dir : ((s < 0) ? 1 : 0);
                if (cmd_brake) begin
                    m_tgt = 0; m_tdir = m_dir; m_duty = 0; m_brake = 1; m_mode = M_BRAKE;
                end else begin
                    if (old_mode == M_BRAKE) begin
                        if (d != m_dir) begin
                            m_mode = M_DEAD;
                            m_dead_left = DEAD_CYCLES;
                        end else begin
                            m_mode = M_RAMP;
                        end
                    end else if (old_mode == M_RAMP && tick_now) begin
                        m_mode = M_RAMP;
                    end else begin
                        m_mode = (mag == m_duty && d == m_dir) ? M_IDLE : M_RAMP;
                    end
                    m_tgt = mag; m_tdir = d; m_brake = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_brake = 1'b0;
        cmd_speed = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    // Present one command and hold it until the edge that accepts it.
    task automatic send_cmd(input int speed, input bit brk);
        int n = 0;
        cmd_speed = W1'(speed);
        cmd_brake = brk;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            cycle();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: cmd_ready stayed low for %0d cycles, required high", n);
        end
        cycle();
        cmd_valid = 1'b0;
        cmd_brake = 1'b0;
    endtask

    // Record every duty change until the output settles at stop_duty/stop_dir.
    logic [DUTY_W-1:0] seen_duty[$];
    int                seen_gap[$];
    bit                seen_dir[$];
    bit                seen_at[$];
    int                nready_cycles;
    int                nready_bad;
    bit                timed_out;

    task automatic capture(input int stop_duty, input bit stop_dir, input int budget);
        logic [DUTY_W-1:0] prev;
        int since = 0;
        prev = duty;
        seen_duty.delete(); seen_gap.delete(); seen_dir.delete(); seen_at.delete();
        nready_cycles = 0;
        nready_bad = 0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            cycle();
            since++;
            if (!cmd_ready) begin
                nready_cycles++;
                if (duty != 0) nready_bad++;
            end
            if (duty != prev) begin
                seen_duty.push_back(duty);
                seen_gap.push_back(since);
                seen_dir.push_back(dir);
                seen_at.push_back(at_target);
                since = 0;
                prev = duty;
            end
            if (duty == DUTY_W'(stop_duty) && dir == stop_dir && at_target) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Wait (bounded) until duty shows a given value.
    task automatic wait_duty(input int val, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (duty == DUTY_W'(val)) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    // ---------------- scenarios ----------------
    logic [DUTY_W-1:0] exp_q[$];

    task automatic test_reset();
        bit ok;
        do_reset();
        checks++; if (duty !== '0) begin failures++; $display("FAIL reset_duty: got %0d required 0", duty); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir: got %b required 0", dir); end
        checks++; if (brake !== 1'b0) begin failures++; $display("FAIL reset_brake: got %b required 0", brake); end
        checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL reset_at_target: got %b required 1", at_target); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
        // Reset in the middle of a ramp.
        send_cmd(100, 1'b0);
        wait_duty(48, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midramp_reach48: duty %0d required 48", duty); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (duty !== '0 || dir !== 1'b0 || brake !== 1'b0 || at_target !== 1'b1 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midramp_reset: duty=%0d dir=%b brake=%b at=%b rdy=%b required 0 0 0 1 1",
                     duty, dir, brake, at_target, cmd_ready);
        end
        // Reset in the middle of dead time.
        send_cmd(-16, 1'b0);
        for (int i = 0; i < 20 && cmd_ready; i++) cycle();
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL middead_enter: cmd_ready %b required 0", cmd_ready); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (duty !== '0 || dir !== 1'b0 || at_target !== 1'b1 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL middead_reset: duty=%0d dir=%b at=%b rdy=%b required 0 0 1 1", duty, dir, at_target, cmd_ready);
        end
    endtask

    task automatic test_ramp_up();
        do_reset();
        send_cmd(100, 1'b0);
        capture(100, 1'b0, 200);
        checks++; if (timed_out) begin failures++; $display("FAIL rampup_settle: duty %0d required 100 with at_target", duty); end
        exp_q = '{16, 32, 48, 64, 80, 96, 100};
        checks++;
        if (seen_duty.size() != exp_q.size()) begin
            failures++; $display("FAIL rampup_count: got %0d steps required %0d", seen_duty.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < seen_duty.size(); i++) begin
            checks++;
            if (seen_duty[i] !== exp_q[i]) begin failures++; $display("FAIL rampup_step%0d: got %0d required %0d", i, seen_duty[i], exp_q[i]); end
            if (i > 0) begin
                checks++;
                if (seen_gap[i] != STEP_DIV) begin failures++; $display("FAIL rampup_gap%0d: got %0d required %0d", i, seen_gap[i], STEP_DIV); end
            end
        end
        if (seen_at.size() == exp_q.size()) begin
            checks++; if (seen_at[exp_q.size()-1] !== 1'b1) begin failures++; $display("FAIL rampup_at_final: got 0 required 1"); end
            checks++; if (seen_at[exp_q.size()-2] !== 1'b0) begin failures++; $display("FAIL rampup_at_early: got 1 required 0"); end
        end
    endtask

    task automatic test_reversal();
        send_cmd(-50, 1'b0);
        capture(50, 1'b1, 300);
        checks++; if (timed_out) begin failures++; $display("FAIL rev_settle: duty=%0d dir=%b required 50 1", duty, dir); end
        exp_q = '{84, 68, 52, 36, 20, 4, 0, 16, 32, 48, 50};
        checks++;
        if (seen_duty.size() != exp_q.size()) begin
            failures++; $display("FAIL rev_count: got %0d steps required %0d", seen_duty.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < seen_duty.size(); i++) begin
            checks++;
            if (seen_duty[i] !== exp_q[i]) begin failures++; $display("FAIL rev_step%0d: got %0d required %0d", i, seen_duty[i], exp_q[i]); end
        end
        if (seen_dir.size() == exp_q.size()) begin
            checks++; if (seen_dir[6] !== 1'b0) begin failures++; $display("FAIL rev_dir_at_zero: got 1 required 0"); end
            checks++; if (seen_dir[7] !== 1'b1) begin failures++; $display("FAIL rev_dir_after_dead: got 0 required 1"); end
        end
        checks++; if (nready_cycles != DEAD_CYCLES) begin failures++; $display("FAIL rev_dead_len: got %0d required %0d", nready_cycles, DEAD_CYCLES); end
        checks++; if (nready_bad != 0) begin failures++; $display("FAIL rev_dead_duty: %0d dead cycles with nonzero duty, required 0", nready_bad); end
    endtask

    task automatic test_saturate();
        bit mono = 1'b1;
        do_reset();
        send_cmd(-1024, 1'b0);
        capture(1023, 1'b1, 800);
        checks++; if (timed_out) begin failures++; $display("FAIL sat_settle: duty=%0d dir=%b required 1023 1", duty, dir); end
        checks++; if (seen_duty.size() != 64) begin failures++; $display("FAIL sat_count: got %0d steps required 64", seen_duty.size()); end
        if (seen_duty.size() == 64) begin
            checks++; if (seen_duty[62] !== 10'd1008) begin failures++; $display("FAIL sat_penult: got %0d required 1008", seen_duty[62]); end
            checks++; if (seen_duty[63] !== 10'd1023) begin failures++; $display("FAIL sat_final: got %0d required 1023", seen_duty[63]); end
        end
        for (int i = 1; i < seen_duty.size(); i++) if (seen_duty[i] <= seen_duty[i-1]) mono = 1'b0;
        checks++; if (!mono) begin failures++; $display("FAIL sat_monotonic: got nonincreasing step required increasing"); end
    endtask

    task automatic test_brake();
        do_reset();
        send_cmd(500, 1'b0);
        capture(500, 1'b0, 300);
        checks++; if (timed_out) begin failures++; $display("FAIL brake_pre: duty %0d required 500", duty); end
        send_cmd(0, 1'b1);
        checks++; if (duty !== '0) begin failures++; $display("FAIL brake_duty: got %0d required 0", duty); end
        checks++; if (brake !== 1'b1) begin failures++; $display("FAIL brake_on: got %b required 1", brake); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL brake_dir: got %b required 0", dir); end
        checks++; if (at_target !== 1'b0) begin failures++; $display("FAIL brake_at: got %b required 0", at_target); end
        repeat (12) cycle();
        checks++; if (duty !== '0 || brake !== 1'b1) begin failures++; $display("FAIL brake_hold: duty=%0d brake=%b required 0 1", duty, brake); end
        send_cmd(20, 1'b0);
        checks++; if (brake !== 1'b0) begin failures++; $display("FAIL brake_release: got %b required 0", brake); end
        capture(20, 1'b0, 100);
        exp_q = '{16, 20};
        checks++;
        if (timed_out || seen_duty.size() != 2 || seen_duty[0] !== exp_q[0] || seen_duty[1] !== exp_q[1]) begin
            failures++; $display("FAIL brake_ramp: got %0d steps ending at %0d required 16,20", seen_duty.size(), duty);
        end
    endtask

    task automatic test_retarget();
        bit ok;
        do_reset();
        send_cmd(200, 1'b0);
        wait_duty(64, ok);
        checks++; if (!ok) begin failures++; $display("FAIL retarget_reach64: duty %0d required 64", duty); end
        send_cmd(40, 1'b0);
        capture(40, 1'b0, 100);
        exp_q = '{48, 40};
        checks++;
        if (timed_out || seen_duty.size() != 2 || seen_duty[0] !== exp_q[0] || seen_duty[1] !== exp_q[1]) begin
            failures++; $display("FAIL retarget_seq: got %0d steps ending at %0d required 48,40", seen_duty.size(), duty);
        end
    endtask

    task automatic test_dead_contention();
        int n = 0;
        do_reset();
        send_cmd(32, 1'b0);
        capture(32, 1'b0, 100);
        send_cmd(-32, 1'b0);
        for (int i = 0; i < 100 && cmd_ready; i++) cycle();
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL cont_dead_enter: cmd_ready %b required 0", cmd_ready); end
        cmd_speed = W1'(48);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            n++;
            cycle();
        end
        checks++; if (n != DEAD_CYCLES) begin failures++; $display("FAIL cont_blocked: held %0d cycles required %0d", n, DEAD_CYCLES); end
        checks++; if (dir !== 1'b1 || duty !== '0) begin failures++; $display("FAIL cont_exit: dir=%b duty=%0d required 1 0", dir, duty); end
        cycle();
        cmd_valid = 1'b0;
        capture(48, 1'b0, 300);
        checks++; if (timed_out) begin failures++; $display("FAIL cont_settle: duty=%0d dir=%b required 48 0", duty, dir); end
    endtask

    task automatic test_random();
        int s;
        bit acc;
        do_reset();
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if (!cmd_valid && $urandom_range(0, 99) < 2) begin
                case ($urandom_range(0, 9))
                    0: s = 0;
                    1: s = -1024;
                    2: s = $urandom_range(0, 1023);
                    3, 4, 5: s = $urandom_range(0, 100);
                    default: s = $urandom_range(0, 1023);
                endcase
                if ($urandom_range(0, 1) == 1 && s > 0) s = -s;
                cmd_speed = W1'(s);
                cmd_brake = ($urandom_range(0, 9) == 0);
                cmd_valid = 1'b1;
            end
            checks++;
            if (duty !== DUTY_W'(m_duty) || dir !== 1'(m_dir) || brake !== 1'(m_brake) ||
                at_target !== (m_mode == M_IDLE) || cmd_ready !== (m_mode != M_DEAD)) begin
                failures++;
                if (failures < 20)
                    $display("FAIL random_cyc%0d: duty=%0d dir=%b brake=%b at=%b rdy=%b required %0d %0d %0d %0d %0d",
                             cyc, duty, dir, brake, at_target, cmd_ready,
                             m_duty, m_dir, m_brake, (m_mode == M_IDLE), (m_mode != M_DEAD));
            end
            acc = cmd_valid && cmd_ready;
            cycle();
            if (acc) begin
                cmd_valid = 1'b0;
                cmd_brake = 1'b0;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_brake = 1'b0;
        cmd_speed = '0;
        test_reset();
        test_ramp_up();
        test_reversal();
        test_saturate();
        test_brake();
        test_retarget();
        test_dead_contention();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motor_ramp.md
# motor_ramp

Slew-rate limiter and direction sequencer placed directly upstream of the PWM generator in each motor channel. Accepts signed speed commands over a valid/ready handshake and moves the PWM duty toward the commanded magnitude in fixed steps at a fixed tick rate. A direction reversal is sequenced as ramp to zero, dead time, flip direction, then ramp up. `duty` drives the PWM `value` input; `dir` and `brake` drive the H-bridge.

## Interface
- `DUTY_W`, 10: duty width; must equal log2 of PWM TOP.
- `STEP_DIV`, 1000: clk cycles per ramp tick (≥2).
- `STEP`, 8: duty change per tick (1 ≤ STEP < 2^DUTY_W).
- `DEAD_CYCLES`, 256: clk cycles with duty 0 before a direction flip (≥1).

- `clk`  in  1: single clock domain; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_speed`  in  DUTY_W+1: signed two's-complement target speed.
- `cmd_brake`  in  1: brake request; qualified by handshake.
- `duty`  out  DUTY_W: PWM magnitude, registered.
- `dir`  out  1: 0 = forward (speed ≥ 0), 1 = reverse; registered.
- `brake`  out  1: bridge brake enable, registered.
- `at_target`  out  1: high when `state==IDLE`.

## Operation
- State is one of four values: IDLE, RAMP, DEAD or BRAKE. Reset state is IDLE.
- Reset values, applied at the next edge with `reset` high (including mid-ramp or mid-dead-time): `duty`=0, `dir`=0, `brake`=0, target=+0, tick counter=0, dead counter=0. With those state values, `at_target`=1 and `cmd_ready`=1.
- `cmd_ready` = (state != DEAD). It is decoded combinationally from the state register.
- **Command accept.**
  - Target magnitude = |cmd_speed|. Compute it in DUTY_W+1 bits. -2^DUTY_W saturates to 2^DUTY_W−1.
  - Target dir = sign bit, except that speed 0 keeps the current `dir`.
  - `cmd_brake`=1 overrides speed: target is cleared, `duty`→0 and `brake`→1 at the next edge, state→BRAKE, `dir` unchanged.
  - A non-brake command from any state except DEAD clears `brake` and enters RAMP. A command equal to the current output enters IDLE instead.
  - A new command replaces the target immediately; there is no queueing.
- **Tick.** A one-cycle pulse every STEP_DIV cycles from a free-running counter that reset clears. Ticks are ignored outside RAMP.
- **RAMP, on tick.**
  - If `dir` differs from the target dir: `duty` = max(duty−STEP, 0). On reaching 0 → DEAD.
  - Otherwise `duty` steps toward the target magnitude by STEP, clamped so it never overshoots. On equality → IDLE.
  - Arithmetic is DUTY_W+1 bits wide and must not wrap.
- **DEAD.** `duty` is held at 0 for exactly DEAD_CYCLES clk cycles. On exit, `dir` toggles and state → RAMP, or IDLE if the target magnitude is 0.
- **BRAKE.** Exit only by an accepted non-brake command.
  - Same dir, or target 0: → RAMP from duty 0.
  - Different dir: → DEAD first. BRAKE counts as stopped but not as dead time.
- **Simultaneous command and tick.** The step on that edge uses the old target. The new target applies from the next tick.

## Timing
- Command → output latency is 1 cycle for brake and for state/`brake` changes.
- The first duty step after a command lands on the next tick edge, 1..STEP_DIV cycles later.
- Consecutive duty changes are exactly STEP_DIV cycles apart.
- `duty` is registered and glitch-free. The PWM samples it at its own period boundary, so the ramp is not phase-aligned to the PWM period.
- A full-reversal latency from speed +M to −N is ceil(M/STEP)+ceil(N/STEP) ticks plus DEAD_CYCLES cycles plus tick alignment.

## Structure
- Package `motor_pkg` holds:
  - the state enum (IDLE, RAMP, DEAD, BRAKE);
  - the dir encoding constants (FWD=0, REV=1).
- Tick generation reuses the existing `Divider #(STEP_DIV)` sub-module, with its `reset` tied to `reset`.
- Dead-time counter width is $clog2(DEAD_CYCLES+1).

## Test plan
All scenarios use DUTY_W=10, STEP_DIV=4, STEP=16, DEAD_CYCLES=8.
- Reset mid-ramp at duty 48: next edge `duty`=0, `dir`=0, `brake`=0, `at_target`=1, `cmd_ready`=1.
- Command +100 from rest: `duty` goes 16, 32, 48, 64, 80, 96, 100, changing every 4 cycles. `at_target` rises on the edge `duty` reaches 100.
- From +100, command −50: `duty` goes 84 … 4, 0. Then 8 cycles of `cmd_ready`=0 with `duty`=0. Then `dir`=1 and `duty` goes 16, 32, 48, 50.
- Command −1024: target saturates to 1023. The final step is clamped from 1008 to 1023, with no wrap to 0.
- At `duty`=500, accept `cmd_brake`: next edge `duty`=0 and `brake`=1. Then command +20: `brake`=0, `duty` ramps 16, 20.
- Retarget and contention:
  - Ramping to +200, at `duty`=64 command +40: `duty` goes 48, 40.
  - A command held valid during DEAD is not accepted until the cycle after DEAD exits.
